// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register and a single-entry skid buffer.
// Drives the imem request handshake and honours hazard-unit stalls and EX redirects.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pc_WE,
   input  logic        WE_if_id,
   input  logic        flush_if_id,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_IF_ID,
   output logic [31:0] pc_plus4_IF_ID,
   output logic        valid_IF_ID
);

   typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] drainAddr_q;
   logic [31:0] skidInstr_q;
   logic [31:0] skidPc4_q;
   logic [31:0] instr_q;
   logic [31:0] pc4_q;
   logic        valid_q;

   logic        accept;
   logic [31:0] pcPlus4_d;

   assign accept    = pc_WE & WE_if_id;
   assign pcPlus4_d = pc_q + 32'd4;

   // Request lines depend only on state and stored addresses, never on imem_ack.
   assign imem_req  = (state_q == FETCH) || (state_q == DRAIN);
   assign imem_addr = (state_q == DRAIN) ? drainAddr_q : pc_q;

   assign instr_IF_ID    = instr_q;
   assign pc_plus4_IF_ID = pc4_q;
   assign valid_IF_ID    = valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= BOOT;
         pc_q        <= RESET_PC;
         drainAddr_q <= 32'd0;
         skidInstr_q <= 32'd0;
         skidPc4_q   <= 32'd0;
         instr_q     <= 32'd0;
         pc4_q       <= 32'd0;
         valid_q     <= 1'b0;
      end else begin
         case (state_q)
            BOOT: begin
               state_q <= FETCH;
            end
            FETCH: begin
               if (flush_if_id) begin
                  pc_q    <= branch_target;
                  valid_q <= 1'b0;
                  if (!imem_ack) begin
                     drainAddr_q <= pc_q;
                     state_q     <= DRAIN;
                  end
               end else if (imem_ack) begin
                  if (accept) begin
                     instr_q <= imem_rdata;
                     pc4_q   <= pcPlus4_d;
                     valid_q <= 1'b1;
                     pc_q    <= pcPlus4_d;
                  end else begin
                     skidInstr_q <= imem_rdata;
                     skidPc4_q   <= pcPlus4_d;
                     state_q     <= HOLD;
                  end
               end else if (WE_if_id) begin
                  valid_q <= 1'b0;
               end
            end
            HOLD: begin
               if (flush_if_id) begin
                  pc_q    <= branch_target;
                  valid_q <= 1'b0;
                  state_q <= FETCH;
               end else if (accept) begin
                  instr_q <= skidInstr_q;
                  pc4_q   <= skidPc4_q;
                  valid_q <= 1'b1;
                  pc_q    <= pcPlus4_d;
                  state_q <= FETCH;
               end
            end
            DRAIN: begin
               // The orphaned response is swallowed here; pc already points at the redirect.
               if (flush_if_id) begin
                  pc_q <= branch_target;
               end
               if (flush_if_id || WE_if_id) begin
                  valid_q <= 1'b0;
               end
               if (imem_ack) begin
                  state_q <= FETCH;
               end
            end
            default: begin
               state_q <= BOOT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: cycle table plus an instruction scoreboard
// fed by a behavioural memory with a programmable wait-state count.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pc_WE;
   logic        WE_if_id;
   logic        flush_if_id;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr_IF_ID;
   logic [31:0] pc_plus4_IF_ID;
   logic        valid_IF_ID;

   fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .pc_WE(pc_WE),
      .WE_if_id(WE_if_id),
      .flush_if_id(flush_if_id),
      .branch_target(branch_target),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_ack(imem_ack),
      .imem_rdata(imem_rdata),
      .instr_IF_ID(instr_IF_ID),
      .pc_plus4_IF_ID(pc_plus4_IF_ID),
      .valid_IF_ID(valid_IF_ID)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          pcWe;
      bit          weIfId;
      bit          flush;
      logic [31:0] target;
      int          waitSt;
      bit          expReq;
      logic [31:0] expAddr;
      bit          expValid;
      logic [31:0] expPc4;
   } vec_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc4;
   } sb_t;

   vec_t vecs[30];
   sb_t  expQ[$];
   int   checks  = 0;
   int   passes  = 0;
   int   waitCnt = 0;

   function automatic logic [31:0] memData(input logic [31:0] a);
      return a ^ 32'h5A5A_5A5A;
   endfunction

   function automatic vec_t mk(input bit pw, input bit we, input bit fl, input logic [31:0] tg,
                               input int ws, input bit rq, input logic [31:0] ad,
                               input bit vl, input logic [31:0] p4);
      vec_t v;
      v.pcWe = pw; v.weIfId = we; v.flush = fl; v.target = tg; v.waitSt = ws;
      v.expReq = rq; v.expAddr = ad; v.expValid = vl; v.expPc4 = p4;
      return v;
   endfunction

   task automatic pushProg(input logic [31:0] a);
      sb_t e;
      e.instr = memData(a);
      e.pc4   = a + 32'd4;
      expQ.push_back(e);
   endtask

   task automatic checkVal(input string name, input int row, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got === want) passes++;
      else $display("[TB] FAIL %s row%0d got %h want %h", name, row, got, want);
   endtask

   task automatic checkOutput(input int r, input bit acc);
      sb_t e;
      checkVal("valid", r, 32'(valid_IF_ID), 32'(vecs[r].expValid));
      if (vecs[r].expValid) checkVal("pc4", r, pc_plus4_IF_ID, vecs[r].expPc4);
      if (acc && valid_IF_ID) begin
         if (expQ.size() == 0) begin
            checks++;
            $display("[TB] FAIL sbUnexpected row%0d got pc4 %h want no load", r, pc_plus4_IF_ID);
         end else begin
            e = expQ.pop_front();
            checkVal("sbInstr", r, instr_IF_ID, e.instr);
            checkVal("sbPc4", r, pc_plus4_IF_ID, e.pc4);
         end
      end
   endtask

   // Entered at a negedge; drives one cycle, memory responds after waitSt request cycles.
   task automatic applyStimulus(input int r);
      vec_t v;
      bit   ackNow, reqNow, accNow;
      v = vecs[r];
      checkVal("req", r, 32'(imem_req), 32'(v.expReq));
      if (v.expReq) checkVal("addr", r, imem_addr, v.expAddr);
      pc_WE         = v.pcWe;
      WE_if_id      = v.weIfId;
      flush_if_id   = v.flush;
      branch_target = v.target;
      reqNow        = imem_req;
      ackNow        = imem_req && (waitCnt >= v.waitSt);
      accNow        = v.pcWe && v.weIfId;
      imem_ack      = ackNow;
      imem_rdata    = ackNow ? memData(imem_addr) : 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      if (ackNow) waitCnt = 0;
      else if (reqNow) waitCnt++;
      checkOutput(r, accNow);
      @(negedge clk);
   endtask

   initial begin
      //          pw we fl target        ws rq addr          vl pc4
      vecs[0]  = mk(1, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0);
      vecs[1]  = mk(1, 1, 0, 32'h0,        0, 1, 32'h0,        1, 32'h4);
      vecs[2]  = mk(1, 1, 0, 32'h0,        0, 1, 32'h4,        1, 32'h8);
      vecs[3]  = mk(0, 0, 0, 32'h0,        0, 1, 32'h8,        1, 32'h8);
      vecs[4]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h8);
      vecs[5]  = mk(1, 1, 0, 32'h0,        0, 0, 32'h0,        1, 32'hC);
      vecs[6]  = mk(1, 1, 0, 32'h0,        0, 1, 32'hC,        1, 32'h10);
      vecs[7]  = mk(1, 1, 0, 32'h0,        3, 1, 32'h10,       0, 32'h0);
      vecs[8]  = mk(1, 1, 0, 32'h0,        3, 1, 32'h10,       0, 32'h0);
      vecs[9]  = mk(1, 1, 0, 32'h0,        3, 1, 32'h10,       0, 32'h0);
      vecs[10] = mk(1, 1, 0, 32'h0,        3, 1, 32'h10,       1, 32'h14);
      vecs[11] = mk(1, 1, 0, 32'h0,        0, 1, 32'h14,       1, 32'h18);
      vecs[12] = mk(1, 1, 0, 32'h0,        0, 1, 32'h18,       1, 32'h1C);
      vecs[13] = mk(1, 1, 0, 32'h0,        0, 1, 32'h1C,       1, 32'h20);
      vecs[14] = mk(1, 1, 1, 32'h100,      3, 1, 32'h20,       0, 32'h0);
      vecs[15] = mk(1, 1, 0, 32'h0,        3, 1, 32'h20,       0, 32'h0);
      vecs[16] = mk(1, 1, 0, 32'h0,        3, 1, 32'h20,       0, 32'h0);
      vecs[17] = mk(1, 1, 0, 32'h0,        3, 1, 32'h20,       0, 32'h0);
      vecs[18] = mk(1, 1, 0, 32'h0,        0, 1, 32'h100,      1, 32'h104);
      vecs[19] = mk(0, 0, 1, 32'h200,      0, 1, 32'h104,      0, 32'h0);
      vecs[20] = mk(1, 1, 0, 32'h0,        0, 1, 32'h200,      1, 32'h204);
      vecs[21] = mk(0, 0, 0, 32'h0,        0, 1, 32'h204,      1, 32'h204);
      vecs[22] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h204);
      vecs[23] = mk(1, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0);
      vecs[24] = mk(1, 1, 1, 32'hFFFF_FFFC, 0, 1, 32'h0,       0, 32'h0);
      vecs[25] = mk(1, 1, 0, 32'h0,        0, 1, 32'hFFFF_FFFC, 1, 32'h0);
      vecs[26] = mk(1, 1, 0, 32'h0,        0, 1, 32'h0,        1, 32'h4);
      vecs[27] = mk(0, 0, 0, 32'h0,        0, 1, 32'h4,        1, 32'h4);
      vecs[28] = mk(0, 0, 1, 32'h40,       0, 0, 32'h0,        0, 32'h0);
      vecs[29] = mk(1, 1, 0, 32'h0,        0, 1, 32'h40,       1, 32'h44);

      rst_n = 1'b1;
      pc_WE = 1'b0; WE_if_id = 1'b0; flush_if_id = 1'b0;
      branch_target = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
      #1 rst_n = 1'b0;
      #2;
      checkVal("rstReq", -1, 32'(imem_req), 32'd0);
      checkVal("rstValid", -1, 32'(valid_IF_ID), 32'd0);
      checkVal("rstInstr", -1, instr_IF_ID, 32'd0);
      checkVal("rstPc4", -1, pc_plus4_IF_ID, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) if (i <= 22) begin end
      pushProg(32'h0);   pushProg(32'h4);   pushProg(32'h8);   pushProg(32'hC);
      pushProg(32'h10);  pushProg(32'h14);  pushProg(32'h18);  pushProg(32'h1C);
      pushProg(32'h100); pushProg(32'h200);
      for (int r = 0; r <= 22; r++) applyStimulus(r);

      // Reset while HOLD owns a buffered instruction; a stray ack during reset must be ignored.
      rst_n      = 1'b0;
      pc_WE      = 1'b1;
      WE_if_id   = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = 32'hBAD0_BAD0;
      #1;
      checkVal("midRstReq", 100, 32'(imem_req), 32'd0);
      checkVal("midRstValid", 100, 32'(valid_IF_ID), 32'd0);
      checkVal("midRstInstr", 100, instr_IF_ID, 32'd0);
      checkVal("midRstPc4", 100, pc_plus4_IF_ID, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      checkVal("rstAckIgnored", 101, 32'(valid_IF_ID), 32'd0);
      checkVal("rstAckInstr", 101, instr_IF_ID, 32'd0);
      @(negedge clk);
      imem_ack = 1'b0;
      waitCnt  = 0;
      rst_n    = 1'b1;

      pushProg(32'hFFFF_FFFC); pushProg(32'h0); pushProg(32'h40);
      for (int r = 23; r <= 29; r++) applyStimulus(r);

      checkVal("sbDrained", 200, 32'(expQ.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
